// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: hazard/redirect inputs, instruction BSRAM port, IF/ID outputs
//   stall, redirect, redirect_pc : control from hazard unit and EX
//   imem_addr, imem_rdata        : synchronous-read instruction BSRAM
//   id_opcode, id_pc, id_valid   : IF/ID pipeline register contents
//   fetch_count                  : delivered-instruction counter
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_opcode;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, id_opcode, id_pc, id_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, id_opcode, id_pc, id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with IF/ID pipeline register
//   clk : core clock, all state on rising edge
//   rst : asynchronous active-high reset
//   fe  : fetch_stage_if.master (control in, BSRAM port, IF/ID outputs)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      fe
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc_f;
    logic        r_f_valid;
    logic [31:0] r_id_opcode;
    logic [31:0] r_id_pc;
    logic        r_id_valid;
    logic [31:0] r_fetch_count;
    logic [31:0] w_imem_addr;
    logic [31:0] w_redirect_aligned;
    logic [31:0] w_pc_plus4;

    assign w_redirect_aligned = fe.redirect_pc & ~32'h0000_0003;
    assign w_pc_plus4         = r_pc_f + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address priority mirrors the register update priority so that the
    // word arriving next cycle always belongs to the PC held in r_pc_f.
    always_comb begin
        w_state_nxt = r_state;
        w_imem_addr = w_pc_plus4;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                w_imem_addr = RESET_PC;
            end
            RUN: begin
                if (fe.redirect) begin
                    w_imem_addr = w_redirect_aligned;
                end else if (fe.stall) begin
                    // Re-read the same word so imem_rdata stays valid while held.
                    w_imem_addr = r_pc_f;
                end
            end
            default: begin
                w_state_nxt = BOOT;
                w_imem_addr = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f        <= RESET_PC;
            r_f_valid     <= 1'b0;
            r_id_opcode   <= NOP_INSN;
            r_id_pc       <= 32'd0;
            r_id_valid    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (r_state == BOOT) begin
            r_pc_f    <= RESET_PC;
            r_f_valid <= 1'b1;
        end else if (fe.redirect) begin
            // The wrong-path word now in IF is dropped; ID gets a bubble.
            r_pc_f      <= w_redirect_aligned;
            r_f_valid   <= 1'b1;
            r_id_opcode <= NOP_INSN;
            r_id_pc     <= 32'd0;
            r_id_valid  <= 1'b0;
        end else if (!fe.stall) begin
            r_pc_f      <= w_pc_plus4;
            r_id_opcode <= r_f_valid ? fe.imem_rdata : NOP_INSN;
            r_id_pc     <= r_pc_f;
            r_id_valid  <= r_f_valid;
            if (r_f_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign fe.imem_addr   = w_imem_addr;
    assign fe.id_opcode   = r_id_opcode;
    assign fe.id_pc       = r_id_pc;
    assign fe.id_valid    = r_id_valid;
    assign fe.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - testbench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic clk;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
        .clk (clk),
        .rst (rst),
        .fe  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word i holds 0x1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: address of the word currently in IF, plus expected ID view.
    bit          m_booted;
    logic [31:0] m_pc;
    bit          m_fv;
    logic [31:0] e_op;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 1'b0;
        m_pc     = RESET_PC;
        m_fv     = 1'b0;
        e_op     = NOP_INSN;
        e_pc     = 32'd0;
        e_v      = 1'b0;
        e_cnt    = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] rp);
        if (!m_booted) begin
            m_booted = 1'b1;
            m_pc     = RESET_PC;
            m_fv     = 1'b1;
        end else if (r) begin
            m_pc = {rp[31:2], 2'b00};
            m_fv = 1'b1;
            e_op = NOP_INSN;
            e_pc = 32'd0;
            e_v  = 1'b0;
        end else if (!s) begin
            e_op  = m_fv ? mem_word(m_pc) : NOP_INSN;
            e_pc  = m_pc;
            e_v   = m_fv;
            e_cnt = e_cnt + (m_fv ? 32'd1 : 32'd0);
            m_pc  = m_pc + 32'd4;
        end
    endtask

    function automatic logic [31:0] exp_addr();
        if (!m_booted)          return RESET_PC;
        else if (bus.redirect)  return {bus.redirect_pc[31:2], 2'b00};
        else if (bus.stall)     return m_pc;
        else                    return m_pc + 32'd4;
    endfunction

    task automatic step();
        logic        s;
        logic        r;
        logic [31:0] rp;
        s  = bus.stall;
        r  = bus.redirect;
        rp = bus.redirect_pc;
        @(posedge clk);
        #1;
        model_edge(s, r, rp);
        chk("id_opcode",   bus.id_opcode,          e_op);
        chk("id_pc",       bus.id_pc,              e_pc);
        chk("id_valid",    {31'd0, bus.id_valid},  {31'd0, e_v});
        chk("fetch_count", bus.fetch_count,        e_cnt);
        chk("imem_addr",   bus.imem_addr,          exp_addr());
    endtask

    task automatic boot_seq();
        step();
        chk("boot_valid0", {31'd0, bus.id_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("boot_pc",  bus.id_pc,     32'(4 * i));
            chk("boot_op",  bus.id_opcode, 32'h1000_0000 + 32'(i));
        end
        chk("boot_cnt", bus.fetch_count, 32'd3);
    endtask

    initial begin
        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op",    bus.id_opcode,          NOP_INSN);
        chk("rst_pc",    bus.id_pc,              32'd0);
        chk("rst_valid", {31'd0, bus.id_valid},  32'd0);
        chk("rst_cnt",   bus.fetch_count,        32'd0);
        chk("rst_addr",  bus.imem_addr,          RESET_PC);
        model_reset();
        rst = 1'b0;

        boot_seq();

        // Stall for three cycles while id_pc = 8.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",  bus.id_pc,       32'h8);
            chk("stall_op",  bus.id_opcode,   32'h1000_0002);
            chk("stall_cnt", bus.fetch_count, 32'd3);
        end
        bus.stall = 1'b0;
        step();
        chk("resume_pc0", bus.id_pc, 32'hC);
        step();
        chk("resume_pc1", bus.id_pc, 32'h10);

        // Plain redirect.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        chk("redir_bubble_op", bus.id_opcode, NOP_INSN);
        chk("redir_bubble_v",  {31'd0, bus.id_valid}, 32'd0);
        bus.redirect = 1'b0;
        step();
        chk("redir_pc", bus.id_pc,     32'h40);
        chk("redir_op", bus.id_opcode, 32'h1000_0010);

        // Redirect overrides stall; target is misaligned.
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h83;
        step();
        chk("rs_bubble_v", {31'd0, bus.id_valid}, 32'd0);
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        step();
        chk("rs_pc", bus.id_pc, 32'h80);

        // PC wrap.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        step();
        chk("wrap_pc0", bus.id_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc1", bus.id_pc, 32'h0000_0000);

        // Advance to id_pc = 0x20, bounded.
        for (int i = 0; i < 20 && bus.id_pc !== 32'h20; i++) step();
        chk("reach_0x20", bus.id_pc, 32'h20);

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1;
        chk("arst_op",    bus.id_opcode,         NOP_INSN);
        chk("arst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("arst_cnt",   bus.fetch_count,       32'd0);
        chk("arst_addr",  bus.imem_addr,         RESET_PC);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        boot_seq();

        // Randomized stall/redirect traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.redirect    = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
